// File: rtl/piso_pkg.sv
// -----------------------------------------------------------------------------
// piso_pkg
// Shared definitions for the parallel-to-serial transmit path.
//   state_t       : controller states (ST_IDLE, ST_SHIFT, ST_PARITY)
//   cnt_width()   : width of a counter able to hold 0..width inclusive
//   DEFAULT_WIDTH : default parallel word width
// ST_PARITY is only reachable when PISO_TX_PARITY_EN is defined.
// -----------------------------------------------------------------------------
package piso_pkg;

    localparam int DEFAULT_WIDTH = 16;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SHIFT  = 2'd1,
        ST_PARITY = 2'd2
    } state_t;

    // Bits needed to count beats 0..width (the counter reaches width after
    // the final data beat).
    function automatic int cnt_width(input int width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/piso_bit_counter.sv
// -----------------------------------------------------------------------------
// piso_bit_counter
// Loadable up-counter with a terminal-count flag, used to track beats of a
// serial frame.
// Ports:
//   clk      : clock, rising edge
//   reset    : synchronous, active-high; clears the count
//   load     : load load_val (has priority over inc)
//   load_val : value loaded on load
//   inc      : advance the count by one
//   cnt      : current count
//   tc       : high while cnt == WIDTH-1
// -----------------------------------------------------------------------------
module piso_bit_counter
    import piso_pkg::*;
#(
    parameter int  WIDTH = DEFAULT_WIDTH,
    localparam int CW    = cnt_width(WIDTH)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          load,
    input  logic [CW-1:0] load_val,
    input  logic          inc,
    output logic [CW-1:0] cnt,
    output logic          tc
);

    localparam logic [CW-1:0] TC_VAL = CW'(WIDTH - 1);

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (inc) begin
            cnt <= cnt + CW'(1);
        end
    end

    assign tc = (cnt == TC_VAL);

endmodule

// File: rtl/piso_tx_ctrl.sv
// -----------------------------------------------------------------------------
// piso_tx_ctrl
// Parallel-to-serial transmit controller. Accepts one WIDTH-bit word per
// in_valid/in_ready handshake and shifts it out one bit per shift_en tick,
// framed with s_valid and s_last.
// Optional feature macro: PISO_TX_PARITY_EN -- appends an even-parity bit
// after the data bits; s_last then marks the parity bit only.
// Ports:
//   clk, reset : clock and synchronous active-high reset
//   in_valid   : upstream word valid (must be held until in_ready)
//   in_ready   : high in IDLE, word accepted on in_valid && in_ready
//   in_data    : parallel word captured on the handshake
//   shift_en   : bit-rate tick, one serial beat per high cycle
//   s_out      : current serial bit (0 when not valid)
//   s_valid    : s_out carries a frame bit
//   s_last     : current bit is the final bit of the frame
//   busy       : frame in progress
// All outputs decode only from registered state, so no input reaches an
// output combinationally.
// -----------------------------------------------------------------------------
module piso_tx_ctrl
    import piso_pkg::*;
#(
    parameter int WIDTH     = DEFAULT_WIDTH,
    parameter int MSB_FIRST = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             shift_en,
    output logic             s_out,
    output logic             s_valid,
    output logic             s_last,
    output logic             busy
);

    localparam int            CW       = cnt_width(WIDTH);
    localparam logic [CW-1:0] LAST_IDX = CW'(WIDTH - 1);

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] sreg;
    logic [CW-1:0]    bit_cnt;
    logic             cnt_tc;
    logic             accept;
    logic             beat;
    logic             last_data_beat;
    logic             head_bit;

    // in_ready is exactly "state is IDLE", so the handshake reduces to this.
    assign accept         = (state == ST_IDLE) && in_valid;
    assign beat           = (state == ST_SHIFT) && shift_en;
    assign last_data_beat = beat && (bit_cnt == LAST_IDX);
    assign head_bit       = (MSB_FIRST != 0) ? sreg[WIDTH-1] : sreg[0];

    piso_bit_counter #(
        .WIDTH (WIDTH)
    ) u_bit_counter (
        .clk      (clk),
        .reset    (reset),
        .load     (accept),
        .load_val ('0),
        .inc      (beat),
        .cnt      (bit_cnt),
        .tc       (cnt_tc)
    );

`ifdef PISO_TX_PARITY_EN
    // Even parity of the captured word, held for the trailing parity beat.
    logic par_bit;

    always_ff @(posedge clk) begin
        if (reset) begin
            par_bit <= 1'b0;
        end else if (accept) begin
            par_bit <= ^in_data;
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // The vacated end of the register fills with 0 on every beat.
    always_ff @(posedge clk) begin
        if (reset) begin
            sreg <= '0;
        end else if (accept) begin
            sreg <= in_data;
        end else if (beat) begin
            if (MSB_FIRST != 0) begin
                sreg <= {sreg[WIDTH-2:0], 1'b0};
            end else begin
                sreg <= {1'b0, sreg[WIDTH-1:1]};
            end
        end
    end

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        s_valid   = 1'b0;
        s_out     = 1'b0;
        s_last    = 1'b0;
        busy      = 1'b1;
        case (state)
            ST_IDLE: begin
                in_ready = 1'b1;
                busy     = 1'b0;
                if (in_valid) begin
                    state_nxt = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                s_valid = 1'b1;
                s_out   = head_bit;
`ifdef PISO_TX_PARITY_EN
                if (last_data_beat) begin
                    state_nxt = ST_PARITY;
                end
`else
                s_last = cnt_tc;
                if (last_data_beat) begin
                    state_nxt = ST_IDLE;
                end
`endif
            end
            ST_PARITY: begin
`ifdef PISO_TX_PARITY_EN
                s_valid = 1'b1;
                s_out   = par_bit;
                s_last  = 1'b1;
                if (shift_en) begin
                    state_nxt = ST_IDLE;
                end
`else
                state_nxt = ST_IDLE;
`endif
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_piso_tx_ctrl.sv
// -----------------------------------------------------------------------------
// tb_piso_tx_ctrl
// Two instances (MSB-first and LSB-first) share all inputs. A table of
// frames with their expected serial sequences is applied first, then
// hand-written reset sequences, then random frames with random shift_en
// checked against a bit-index model of the serial stream.
// -----------------------------------------------------------------------------
module tb_piso_tx_ctrl;

    localparam int W = 16;
`ifdef PISO_TX_PARITY_EN
    localparam int PAR = 1;
`else
    localparam int PAR = 0;
`endif
    localparam int BEATS = W + PAR;

    logic         clk = 1'b0;
    logic         reset;
    logic         in_valid;
    logic [W-1:0] in_data;
    logic         shift_en;

    logic rdy_m, out_m, vld_m, last_m, busy_m;
    logic rdy_l, out_l, vld_l, last_l, busy_l;

    int vectors    = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    piso_tx_ctrl #(.WIDTH(W), .MSB_FIRST(1)) dut_msb (
        .clk      (clk),
        .reset    (reset),
        .in_valid (in_valid),
        .in_ready (rdy_m),
        .in_data  (in_data),
        .shift_en (shift_en),
        .s_out    (out_m),
        .s_valid  (vld_m),
        .s_last   (last_m),
        .busy     (busy_m)
    );

    piso_tx_ctrl #(.WIDTH(W), .MSB_FIRST(0)) dut_lsb (
        .clk      (clk),
        .reset    (reset),
        .in_valid (in_valid),
        .in_ready (rdy_l),
        .in_data  (in_data),
        .shift_en (shift_en),
        .s_out    (out_l),
        .s_valid  (vld_l),
        .s_last   (last_l),
        .busy     (busy_l)
    );

    typedef struct {
        logic [W-1:0] data;
        logic [W-1:0] msb_seq;   // expected MSB-first stream, first bit at [W-1]
        logic [W-1:0] lsb_seq;   // expected LSB-first stream, first bit at [W-1]
        logic         par;
        int           period;    // shift_en every period-th cycle
        bit           hold;      // keep in_valid high with nxt while busy
        logic [W-1:0] nxt;
        int           exp_cycles;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, got, exp);
        end
    endtask

    task automatic check_idle(input string tag);
        chk({tag, "_in_ready_m"}, rdy_m, 1);
        chk({tag, "_busy_m"},     busy_m, 0);
        chk({tag, "_s_valid_m"},  vld_m, 0);
        chk({tag, "_s_out_m"},    out_m, 0);
        chk({tag, "_s_last_m"},   last_m, 0);
        chk({tag, "_in_ready_l"}, rdy_l, 1);
        chk({tag, "_busy_l"},     busy_l, 0);
        chk({tag, "_s_valid_l"},  vld_l, 0);
        chk({tag, "_s_out_l"},    out_l, 0);
        chk({tag, "_s_last_l"},   last_l, 0);
    endtask

    function automatic logic [W-1:0] bitrev(input logic [W-1:0] d);
        logic [W-1:0] r;
        for (int i = 0; i < W; i++) r[i] = d[W-1-i];
        return r;
    endfunction

    // Entered at a negedge with both DUTs idle. period==0 means random shift_en.
    task automatic run_frame(input logic [W-1:0] data, input logic [W-1:0] msb_seq,
                             input logic [W-1:0] lsb_seq, input logic par,
                             input int period, input bit hold,
                             input logic [W-1:0] nxt, input int exp_cycles);
        int   k;
        int   j;
        int   cyc;
        int   busy_cnt;
        logic exp_m;
        logic exp_l;
        logic se;
        check_idle("pre");
        in_valid = 1'b1;
        in_data  = data;
        shift_en = 1'($urandom_range(0, 1));
        @(posedge clk);
        @(negedge clk);
        if (hold) begin
            in_valid = 1'b1;
            in_data  = nxt;
        end else begin
            in_valid = 1'b0;
            in_data  = W'($urandom);
        end
        k = 0; j = 0; cyc = 0; busy_cnt = 0;
        while (k < BEATS && cyc < 4000) begin
            if (k < W) begin
                exp_m = msb_seq[W-1-k];
                exp_l = lsb_seq[W-1-k];
            end else begin
                exp_m = par;
                exp_l = par;
            end
            chk("s_out_m", out_m, exp_m);
            chk("s_out_l", out_l, exp_l);
            chk("s_valid_m", vld_m, 1);
            chk("s_valid_l", vld_l, 1);
            chk("s_last_m", last_m, (k == BEATS - 1));
            chk("s_last_l", last_l, (k == BEATS - 1));
            chk("in_ready_busy_m", rdy_m, 0);
            chk("in_ready_busy_l", rdy_l, 0);
            if (busy_m && busy_l) busy_cnt++;
            if (period > 0) se = (j == period - 1);
            else            se = ($urandom_range(0, 2) == 0);
            shift_en = se;
            @(posedge clk);
            @(negedge clk);
            cyc++;
            if (se) begin
                k++;
                j = 0;
            end else begin
                j++;
            end
        end
        if (cyc >= 4000) chk("frame_timeout", cyc, 0);
        if (period > 0) chk("busy_cycles", busy_cnt, exp_cycles);
        shift_en = 1'($urandom_range(0, 1));
    endtask

    vec_t tbl[6];

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [W-1:0] cur;
        logic [W-1:0] nx;
        bit           h;
        int           per;

        tbl[0] = '{16'hA5C3, 16'hA5C3, 16'hC3A5, 1'b0, 1, 1'b0, 16'h0000, BEATS * 1};
        tbl[1] = '{16'h00FF, 16'h00FF, 16'hFF00, 1'b0, 3, 1'b0, 16'h0000, BEATS * 3};
        tbl[2] = '{16'h1234, 16'h1234, 16'h2C48, 1'b1, 1, 1'b1, 16'h5678, BEATS * 1};
        tbl[3] = '{16'h5678, 16'h5678, 16'h1E6A, 1'b0, 2, 1'b0, 16'h0000, BEATS * 2};
        tbl[4] = '{16'h0001, 16'h0001, 16'h8000, 1'b1, 1, 1'b0, 16'h0000, BEATS * 1};
        tbl[5] = '{16'h8000, 16'h8000, 16'h0001, 1'b1, 2, 1'b0, 16'h0000, BEATS * 2};

        reset    = 1'b1;
        in_valid = 1'b0;
        in_data  = '0;
        shift_en = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_idle("reset");
        reset = 1'b0;

        for (int i = 0; i < 6; i++) begin
            run_frame(tbl[i].data, tbl[i].msb_seq, tbl[i].lsb_seq, tbl[i].par,
                      tbl[i].period, tbl[i].hold, tbl[i].nxt, tbl[i].exp_cycles);
        end

        // Abort after five beats of 16'hFFFF.
        check_idle("pre_abort");
        in_valid = 1'b1;
        in_data  = 16'hFFFF;
        shift_en = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            chk("abort_bits_m", out_m, 1);
            chk("abort_bits_l", out_l, 1);
            @(posedge clk);
            @(negedge clk);
        end
        chk("abort_busy_before_m", busy_m, 1);
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        reset    = 1'b0;
        shift_en = 1'b0;
        check_idle("abort");
        run_frame(16'h0001, 16'h0001, 16'h8000, 1'b1, 1, 1'b0, 16'h0000, BEATS);

        // Reset and handshake in the same cycle: the word is dropped.
        reset    = 1'b1;
        in_valid = 1'b1;
        in_data  = 16'hBEEF;
        @(posedge clk);
        @(negedge clk);
        reset    = 1'b0;
        in_valid = 1'b0;
        check_idle("rst_hs");
        @(posedge clk);
        @(negedge clk);
        check_idle("rst_hs_after");

        // Random frames; held in_valid chains straight into the next word.
        cur = W'($urandom);
        for (int i = 0; i < 30; i++) begin
            h   = (i != 29) && ($urandom_range(0, 1) == 1);
            nx  = W'($urandom);
            per = $urandom_range(0, 3);
            run_frame(cur, cur, bitrev(cur), ^cur, per, h, nx, BEATS * per);
            cur = h ? nx : W'($urandom);
        end

        in_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check_idle("final");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
